imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side companion to the byte-addressable instruction memory (256 bytes, 64 big-endian 32-bit instructions).
- Accepts 32-bit instruction words over a valid/ready stream and writes them one byte per cycle through the memory's byte write port.
- Word byte order is big-endian: byte [31:24] goes to the lowest address, so fetch reads each word back unchanged.
- Sits between the boot/debug host path and the instruction memory write port. Runs only while the CPU is held off fetch.

Parameters:
- ADDR_WIDTH, 8, byte address width of the instruction memory.
- MAX_WORDS, 64, capacity in words, equal to 2**ADDR_WIDTH/4.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first byte address; must be word-aligned.
- word_count  input  7  number of words to load, 0..MAX_WORDS.
- in_word  input  32  instruction word.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  loader can accept a word this cycle.
- mem_wr_en  output  1  byte write strobe.
- mem_wr_addr  output  ADDR_WIDTH  byte write address.
- mem_wr_data  output  8  byte write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  sticky flag: a start request was rejected.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE
  - in_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0
  - busy=0, done=0, err=0
  - internal pointer, byte index, words_left and word register all 0.
- States: IDLE, WAIT_WORD, WRITE, DONE. All outputs are decoded from registered state, so there are no input-to-output combinational paths.
- IDLE, on start=1:
  - err is cleared, then the request is validated.
  - Reject when base_addr[1:0]!=0, or word_count>MAX_WORDS, or base_addr + 4*word_count > 2**ADDR_WIDTH. The sum is computed at ADDR_WIDTH+2 bits, so no wrap.
  - On reject: err=1, stay in IDLE.
  - Accept with word_count==0: go to DONE.
  - Accept otherwise: ptr=base_addr, words_left=word_count, go to WAIT_WORD.
- WAIT_WORD:
  - in_ready=1.
  - On in_valid && in_ready: latch in_word, set byte_idx=0, go to WRITE.
  - in_valid=0 holds the state indefinitely.
- WRITE:
  - in_ready=0, mem_wr_en=1, mem_wr_addr=ptr.
  - mem_wr_data = word[31:24], [23:16], [15:8], [7:0] for byte_idx 0..3.
  - Each cycle: ptr+=1, byte_idx+=1.
  - After byte_idx 3: words_left-=1. If words_left was 1, go to DONE; else go to WAIT_WORD.
- DONE: done=1 for exactly one cycle, then IDLE.
- Throughput: 5 cycles per word minimum (1 accept + 4 writes). First write occurs the cycle after the handshake.
- start while busy is ignored; parameters already latched are unaffected.
- ptr never wraps. Range checking at start guarantees the last write address is at most 2**ADDR_WIDTH-1.
- Reset mid-load:
  - Aborts immediately; no further writes.
  - Bytes already written remain in memory.
  - No done pulse is produced.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [31:0].
  - checksum is the modulo-2**32 sum of all words accepted since the last accepted start.
  - Cleared to 0 on reset and on each accepted start; updated on each word handshake.
  - Stable and valid during the done pulse and afterwards.
- When undefined: no port and no adder logic.

Test Plan:
- Basic load: reset, start base=0x00 count=2, words 0x8C010004 then 0x00221820 → writes (00:8C)(01:01)(02:00)(03:04)(04:00)(05:22)(06:18)(07:20) on consecutive cycles per word; done pulses once; err=0.
- Misaligned start: base=0x02, count=1 → err=1, busy=0, no mem_wr_en ever.
- Range check, full memory: base=0xFC, count=1 → accepted, last write at 0xFF. base=0xFC, count=2 → err=1.
- Backpressure and zero count: in_valid low for 10 cycles in WAIT_WORD → in_ready stays 1, no writes. count=0 → done one cycle after start, no writes.
- Reset mid-load: assert reset during byte_idx 2 of word 1 → mem_wr_en=0 immediately, all outputs at reset values, memory bytes 0..1 of that word retained.
- With IMEM_LOADER_CHECKSUM_EN defined: words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001 at done.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Writer-side companion to the byte-addressable instruction memory. Accepts
// 32-bit instruction words over a valid/ready stream and writes each one as
// four big-endian bytes (bits [31:24] at the lowest address), one byte per
// cycle, through the memory's byte write port.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the checksum output.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high. in_ready depends only on registered state, never on in_valid.
// The producer holds in_word stable while in_valid is high and unaccepted.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        one-cycle load request, sampled only in IDLE
//   base_addr    first byte address (must be word-aligned)
//   word_count   number of words to load, 0..MAX_WORDS
//   in_word      instruction word
//   in_valid     in_word is valid
//   in_ready     loader accepts a word this cycle
//   mem_wr_en    byte write strobe
//   mem_wr_addr  byte write address
//   mem_wr_data  byte write data
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a load completes
//   err          sticky: last start request was rejected
//   state_dbg    current FSM state (debug)
//   checksum     mod-2**32 sum of words accepted since last accepted start
//                (only with IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [6:0]            word_count,
  input  logic [31:0]           in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int SW = ADDR_WIDTH + 2;
  localparam logic [SW-1:0] MEM_BYTES = SW'(2 ** ADDR_WIDTH);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [1:0]            byte_idx;
  logic [6:0]            words_left;
  logic [31:0]           word_reg;

  // End address computed two bits wider than the address so that an
  // oversized request cannot wrap around and look valid.
  logic [SW-1:0] end_addr;
  logic          reject;
  logic          accept;
  logic          handshake;

  assign end_addr  = SW'(base_addr) + (SW'(word_count) << 2);
  assign reject    = (base_addr[1:0] != 2'b00) ||
                     (word_count > 7'(MAX_WORDS)) ||
                     (end_addr > MEM_BYTES);
  assign accept    = (state == IDLE) && start && !reject;
  assign handshake = (state == WAIT_WORD) && in_valid;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !reject) begin
          state_next = (word_count == 7'd0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (in_valid) state_next = WRITE;
      end
      WRITE: begin
        if (byte_idx == 2'd3) begin
          state_next = (words_left == 7'd1) ? DONE : WAIT_WORD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      byte_idx   <= '0;
      words_left <= '0;
      word_reg   <= '0;
      err        <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        err <= reject;
        if (!reject) begin
          ptr        <= base_addr;
          words_left <= word_count;
        end
      end
      if (handshake) begin
        word_reg <= in_word;
        byte_idx <= 2'd0;
      end
      if (state == WRITE) begin
        ptr      <= ptr + 1'b1;
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) words_left <= words_left - 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          checksum <= '0;
    else if (accept)    checksum <= '0;
    else if (handshake) checksum <= checksum + in_word;
  end
`endif

  // Outputs decoded from registered state only
  logic [7:0] byte_sel;
  always_comb begin
    byte_sel = 8'h00;
    case (byte_idx)
      2'd0: byte_sel = word_reg[31:24];
      2'd1: byte_sel = word_reg[23:16];
      2'd2: byte_sel = word_reg[15:8];
      2'd3: byte_sel = word_reg[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  assign in_ready    = (state == WAIT_WORD);
  assign mem_wr_en   = (state == WRITE);
  assign mem_wr_addr = (state == WRITE) ? ptr : '0;
  assign mem_wr_data = (state == WRITE) ? byte_sel : 8'h00;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [6:0] word_count = 7'd0;
  logic [31:0] in_word = 32'h0;
  logic       in_valid = 1'b0;
  logic       in_ready, mem_wr_en, busy, done, err;
  logic [7:0] mem_wr_addr, mem_wr_data;
  logic [1:0] state_dbg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .state_dbg  (state_dbg)
  );

  // Memory model and event counters
  logic [7:0] mem_model [256];
  int wr_cnt = 0;
  int done_cnt = 0;
  initial for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem_model[mem_wr_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hand one word over and check its four byte writes, one per cycle.
  task automatic load_word(input logic [31:0] w, input logic [7:0] addr);
    in_word  = w;
    in_valid = 1'b1;
    chk("lw_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_wr_en", 32'(mem_wr_en), 32'd1);
      chk("lw_wr_addr", 32'(mem_wr_addr), 32'(addr + 8'(i)));
      chk("lw_wr_data", 32'(mem_wr_data), 32'(w[31-8*i -: 8]));
      chk("lw_in_ready_low", 32'(in_ready), 32'd0);
      step();
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    step();
    start = 1'b0;
  endtask

  int wr_snap;
  int done_snap;

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Basic load: two words at 0x00
    do_start(8'h00, 7'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_wait_ready", 32'(in_ready), 32'd1);
    load_word(32'h8C010004, 8'h00);
    chk("basic_between_ready", 32'(in_ready), 32'd1);
    chk("basic_between_wr_en", 32'(mem_wr_en), 32'd0);
    load_word(32'h00221820, 8'h04);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_done_busy", 32'(busy), 32'd1);
    step();
    chk("basic_done_pulse_end", 32'(done), 32'd0);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_wr_cnt", 32'(wr_cnt), 32'd8);
    chk("basic_mem_lo", {mem_model[0], mem_model[1], mem_model[2], mem_model[3]}, 32'h8C010004);
    chk("basic_mem_hi", {mem_model[4], mem_model[5], mem_model[6], mem_model[7]}, 32'h00221820);

    // Misaligned start
    wr_snap = wr_cnt;
    do_start(8'h02, 7'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("mis_no_write", 32'(wr_cnt), 32'(wr_snap));
    chk("mis_err_sticky", 32'(err), 32'd1);

    // Full-range boundary: last word of memory is accepted
    do_start(8'hFC, 7'd1);
    chk("fc1_err_cleared", 32'(err), 32'd0);
    chk("fc1_busy", 32'(busy), 32'd1);
    load_word(32'hDEADBEEF, 8'hFC);
    chk("fc1_done", 32'(done), 32'd1);
    step();
    chk("fc1_mem_ff", 32'(mem_model[255]), 32'hEF);
    chk("fc1_mem_fc", 32'(mem_model[252]), 32'hDE);

    // One word past the end, too many words, overflow from an aligned base
    do_start(8'hFC, 7'd2);
    chk("fc2_err", 32'(err), 32'd1);
    chk("fc2_busy", 32'(busy), 32'd0);
    do_start(8'h00, 7'd65);
    chk("cnt65_err", 32'(err), 32'd1);
    do_start(8'h04, 7'd64);
    chk("b4_c64_err", 32'(err), 32'd1);
    chk("b4_c64_busy", 32'(busy), 32'd0);
    do_start(8'h00, 7'd0);
    chk("c0_err_cleared", 32'(err), 32'd0);
    step();

    // Backpressure: in_valid low for 10 cycles; stray start while busy
    wr_snap = wr_cnt;
    do_start(8'h10, 7'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        base_addr = 8'h02;
        word_count = 7'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("bp_ready", 32'(in_ready), 32'd1);
      chk("bp_no_wr", 32'(mem_wr_en), 32'd0);
      step();
    end
    start = 1'b0;
    chk("bp_no_writes", 32'(wr_cnt), 32'(wr_snap));
    chk("bp_start_ignored_err", 32'(err), 32'd0);
    load_word(32'h11223344, 8'h10);
    chk("bp_done", 32'(done), 32'd1);
    step();
    chk("bp_idle", 32'(busy), 32'd0);

    // Zero count: done on the cycle after start, no writes
    wr_snap = wr_cnt;
    done_snap = done_cnt;
    do_start(8'h20, 7'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd1);
    chk("z_ready", 32'(in_ready), 32'd0);
    step();
    chk("z_done_end", 32'(done), 32'd0);
    chk("z_no_writes", 32'(wr_cnt), 32'(wr_snap));
    chk("z_done_cnt", 32'(done_cnt), 32'(done_snap + 1));

    // Reset during byte_idx 2 of the first word
    wr_snap = wr_cnt;
    done_snap = done_cnt;
    do_start(8'h40, 7'd2);
    in_word = 32'hA1B2C3D4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rm_pre_addr", 32'(mem_wr_addr), 32'h42);
    reset = 1'b1;
    #1;
    chk("rm_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rm_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rm_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_ready", 32'(in_ready), 32'd0);
    chk("rm_done", 32'(done), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("rm_wr_count", 32'(wr_cnt), 32'(wr_snap + 2));
    chk("rm_mem40", 32'(mem_model[8'h40]), 32'hA1);
    chk("rm_mem41", 32'(mem_model[8'h41]), 32'hB2);
    chk("rm_mem42", 32'(mem_model[8'h42]), 32'h00);
    chk("rm_no_done", 32'(done_cnt), 32'(done_snap));
    chk("rm_idle", 32'(busy), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum wraps modulo 2**32
    do_start(8'h80, 7'd2);
    chk("cs_cleared", checksum, 32'h0);
    load_word(32'hFFFFFFFF, 8'h80);
    load_word(32'h00000002, 8'h84);
    chk("cs_done", 32'(done), 32'd1);
    chk("cs_value", checksum, 32'h00000001);
    step();
    chk("cs_stable", checksum, 32'h00000001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
